axi_req_tag_arbiter: RTL and testbench



---
 rtl/axi_req_tag_arbiter_pkg.sv | 29 ++
 rtl/axi_req_tag_arbiter_tag_free_pool.sv | 48 ++++
 rtl/axi_req_tag_arbiter.sv | 127 ++++++++++++
 tb/tb_axi_req_tag_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_req_tag_arbiter_pkg.sv
// Shared types and widths for the AXI request/tag arbiter on the TX path.
package axi_req_tag_arbiter_pkg;

  localparam int unsigned ID_WIDTH                 = 4;
  localparam int unsigned TAG_WIDTH                = 8;
  localparam int unsigned LEN_WIDTH                = 8;
  localparam int unsigned REQUESTER_RECORDER_WIDTH = ID_WIDTH + 1;
  localparam int unsigned REQUESTER_RECORDER_DEPTH = 1 << TAG_WIDTH;
  localparam int unsigned REC_WIDTH                = REQUESTER_RECORDER_WIDTH;
  localparam int unsigned CNT_WIDTH                = TAG_WIDTH + 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HDR,
    ARB_WDATA
  } arb_state_t;

  typedef enum logic {
    DIR_READ,
    DIR_WRITE
  } req_dir_t;

  // Requester recorder entry: direction plus the originating AxID.
  typedef struct packed {
    logic                is_write;
    logic [ID_WIDTH-1:0] id;
  } rec_entry_t;

endpackage

// File: rtl/axi_req_tag_arbiter_tag_free_pool.sv
// Free-tag pool: one bit per PCIe tag, lowest-index allocation, free count
// and a sticky error for releasing a tag that is already free.
module tag_free_pool
  import axi_req_tag_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc,
  input  logic                 rel,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  output logic [TAG_WIDTH-1:0] free_tag_c,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 err
);

  logic [REQUESTER_RECORDER_DEPTH-1:0] free_vec;
  logic                                rel_ok;
  logic                                rel_dup;
  logic                                alloc_ok;

  // Priority encoder: lowest set bit of the free vector wins.
  always_comb begin
    free_tag_c = '0;
    for (int i = int'(REQUESTER_RECORDER_DEPTH) - 1; i >= 0; i--) begin
      if (free_vec[i]) free_tag_c = TAG_WIDTH'(i);
    end
  end

  assign rel_ok   = rel && !free_vec[rel_tag];
  assign rel_dup  = rel && free_vec[rel_tag];
  assign alloc_ok = alloc && (count != '0);

  // Allocated tag is always free and a valid release is always busy, so the
  // two bit updates never target the same index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free_vec <= '1;
      count    <= CNT_WIDTH'(REQUESTER_RECORDER_DEPTH);
      err      <= 1'b0;
    end else begin
      if (alloc_ok) free_vec[free_tag_c] <= 1'b0;
      if (rel_ok)   free_vec[rel_tag]    <= 1'b1;
      if (rel_dup)  err                  <= 1'b1;
      count <= count + CNT_WIDTH'(rel_ok) - CNT_WIDTH'(alloc_ok);
    end
  end

endmodule

// File: rtl/axi_req_tag_arbiter.sv
// Round-robin write/read request arbiter with PCIe tag allocation,
// requester recording and W-beat sequencing for the TLP builder.
module axi_req_tag_arbiter
  import axi_req_tag_arbiter_pkg::*;
(
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 aw_empty,
  input  logic [ID_WIDTH-1:0]  aw_id,
  input  logic [LEN_WIDTH-1:0] aw_len,
  input  logic                 aw_posted,
  output logic                 aw_pop,
  input  logic                 w_empty,
  output logic                 w_pop,
  input  logic                 ar_empty,
  input  logic [ID_WIDTH-1:0]  ar_id,
  output logic                 ar_pop,
  output logic                 tlp_hdr_valid,
  output logic                 tlp_data_valid,
  input  logic                 tlp_ready,
  output logic                 tlp_is_write,
  output logic [TAG_WIDTH-1:0] tlp_tag,
  output logic [ID_WIDTH-1:0]  tlp_id,
  output logic                 rec_wr_en,
  output logic [TAG_WIDTH-1:0] rec_addr,
  output logic [REC_WIDTH-1:0] rec_data,
  input  logic                 tag_release,
  input  logic [TAG_WIDTH-1:0] tag_release_tag,
  output logic [CNT_WIDTH-1:0] free_tag_count,
  output logic                 tag_err
);

  arb_state_t           state;
  req_dir_t             rr_last;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 wr_req;
  logic                 rd_req;
  logic                 grant_w;
  logic                 grant_r;
  logic                 alloc;
  logic [TAG_WIDTH-1:0] free_tag;
  rec_entry_t           rec_entry;

  tag_free_pool u_pool (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .alloc      (alloc),
    .rel        (tag_release),
    .rel_tag    (tag_release_tag),
    .free_tag_c (free_tag),
    .count      (free_tag_count),
    .err        (tag_err)
  );

  // Grant decision, FIFO pops and recorder write happen in the IDLE cycle;
  // everything is gated by reset so nothing pops while it is asserted.
  always_comb begin
    wr_req         = !aw_empty && (aw_posted || free_tag_count != '0);
    rd_req         = !ar_empty && (free_tag_count != '0);
    grant_w        = 1'b0;
    grant_r        = 1'b0;
    rec_wr_en      = 1'b0;
    rec_addr       = '0;
    rec_data       = '0;
    tlp_data_valid = 1'b0;
    w_pop          = 1'b0;
    if (ARESETn && state == ARB_IDLE) begin
      grant_w = wr_req && (!rd_req || rr_last == DIR_READ);
      grant_r = rd_req && !grant_w;
    end
    alloc              = grant_r || (grant_w && !aw_posted);
    rec_entry.is_write = grant_w;
    rec_entry.id       = grant_w ? aw_id : ar_id;
    if (alloc) begin
      rec_wr_en = 1'b1;
      rec_addr  = free_tag;
      rec_data  = rec_entry;
    end
    if (ARESETn && state == ARB_WDATA) begin
      tlp_data_valid = !w_empty;
      w_pop          = !w_empty && tlp_ready;
    end
    aw_pop = grant_w;
    ar_pop = grant_r;
  end

  // Request FSM with registered header fields and beat counter.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state         <= ARB_IDLE;
      rr_last       <= DIR_READ;
      beat_cnt      <= '0;
      tlp_hdr_valid <= 1'b0;
      tlp_is_write  <= 1'b0;
      tlp_tag       <= '0;
      tlp_id        <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_w || grant_r) begin
            state         <= ARB_HDR;
            tlp_hdr_valid <= 1'b1;
            tlp_is_write  <= grant_w;
            tlp_id        <= rec_entry.id;
            tlp_tag       <= alloc ? free_tag : '0;
            beat_cnt      <= grant_w ? aw_len : '0;
            rr_last       <= grant_w ? DIR_WRITE : DIR_READ;
          end
        end
        ARB_HDR: begin
          if (tlp_ready) begin
            tlp_hdr_valid <= 1'b0;
            state         <= tlp_is_write ? ARB_WDATA : ARB_IDLE;
          end
        end
        ARB_WDATA: begin
          if (w_pop) begin
            if (beat_cnt == '0) state <= ARB_IDLE;
            else                beat_cnt <= beat_cnt - LEN_WIDTH'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_req_tag_arbiter.sv
// Directed self-checking bench for axi_req_tag_arbiter.
module tb_axi_req_tag_arbiter;
  import axi_req_tag_arbiter_pkg::*;

  logic                 ACLK = 1'b0;
  logic                 ARESETn = 1'b0;
  logic                 aw_empty = 1'b1;
  logic [ID_WIDTH-1:0]  aw_id = '0;
  logic [LEN_WIDTH-1:0] aw_len = '0;
  logic                 aw_posted = 1'b0;
  logic                 w_empty = 1'b1;
  logic                 ar_empty = 1'b1;
  logic [ID_WIDTH-1:0]  ar_id = '0;
  logic                 tlp_ready = 1'b0;
  logic                 tag_release = 1'b0;
  logic [TAG_WIDTH-1:0] tag_release_tag = '0;

  logic                 aw_pop, w_pop, ar_pop;
  logic                 tlp_hdr_valid, tlp_data_valid, tlp_is_write;
  logic [TAG_WIDTH-1:0] tlp_tag, rec_addr;
  logic [ID_WIDTH-1:0]  tlp_id;
  logic                 rec_wr_en;
  logic [REC_WIDTH-1:0] rec_data;
  logic [CNT_WIDTH-1:0] free_tag_count;
  logic                 tag_err;

  int n_cmp = 0;
  int n_bad = 0;

  axi_req_tag_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .aw_empty(aw_empty), .aw_id(aw_id), .aw_len(aw_len), .aw_posted(aw_posted), .aw_pop(aw_pop),
    .w_empty(w_empty), .w_pop(w_pop),
    .ar_empty(ar_empty), .ar_id(ar_id), .ar_pop(ar_pop),
    .tlp_hdr_valid(tlp_hdr_valid), .tlp_data_valid(tlp_data_valid), .tlp_ready(tlp_ready),
    .tlp_is_write(tlp_is_write), .tlp_tag(tlp_tag), .tlp_id(tlp_id),
    .rec_wr_en(rec_wr_en), .rec_addr(rec_addr), .rec_data(rec_data),
    .tag_release(tag_release), .tag_release_tag(tag_release_tag),
    .free_tag_count(free_tag_count), .tag_err(tag_err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    aw_empty = 1'b1; aw_posted = 1'b0; aw_id = '0; aw_len = '0;
    w_empty = 1'b1; ar_empty = 1'b1; ar_id = '0;
    tlp_ready = 1'b0; tag_release = 1'b0; tag_release_tag = '0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    ARESETn = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
    settle();
  endtask

  task automatic test_reset;
    idle_inputs();
    ARESETn = 1'b0;
    tick();
    tick();
    n_cmp++; if ({aw_pop, ar_pop, w_pop, tlp_hdr_valid, tlp_data_valid, rec_wr_en, tag_err, tlp_is_write} !== 8'h00) begin n_bad++; $display("FAIL reset_flags: got %b want 00000000", {aw_pop, ar_pop, w_pop, tlp_hdr_valid, tlp_data_valid, rec_wr_en, tag_err, tlp_is_write}); end
    n_cmp++; if ({tlp_tag, tlp_id, rec_addr, rec_data} !== 25'h0) begin n_bad++; $display("FAIL reset_fields: got %h want 0", {tlp_tag, tlp_id, rec_addr, rec_data}); end
    n_cmp++; if (free_tag_count !== 9'd256) begin n_bad++; $display("FAIL reset_count: got %0d want 256", free_tag_count); end
    ARESETn = 1'b1;
    settle();
  endtask

  task automatic test_read_single;
    apply_reset();
    ar_empty = 1'b0; ar_id = 4'd3;
    settle();
    n_cmp++; if ({ar_pop, aw_pop, rec_wr_en} !== 3'b101) begin n_bad++; $display("FAIL rd_grant_pops: got %b want 101", {ar_pop, aw_pop, rec_wr_en}); end
    n_cmp++; if (rec_addr !== 8'd0) begin n_bad++; $display("FAIL rd_rec_addr: got %0d want 0", rec_addr); end
    n_cmp++; if (rec_data !== 5'b0_0011) begin n_bad++; $display("FAIL rd_rec_data: got %b want 00011", rec_data); end
    tick();
    ar_empty = 1'b1;
    settle();
    n_cmp++; if ({tlp_hdr_valid, tlp_is_write, ar_pop} !== 3'b100) begin n_bad++; $display("FAIL rd_hdr_flags: got %b want 100", {tlp_hdr_valid, tlp_is_write, ar_pop}); end
    n_cmp++; if ({tlp_tag, tlp_id} !== {8'd0, 4'd3}) begin n_bad++; $display("FAIL rd_hdr_fields: got tag %0d id %0d want tag 0 id 3", tlp_tag, tlp_id); end
    n_cmp++; if (free_tag_count !== 9'd255) begin n_bad++; $display("FAIL rd_count: got %0d want 255", free_tag_count); end
    tick();
    n_cmp++; if ({tlp_hdr_valid, tlp_tag, tlp_id} !== {1'b1, 8'd0, 4'd3}) begin n_bad++; $display("FAIL rd_hdr_hold: got %h want 1003", {tlp_hdr_valid, tlp_tag, tlp_id}); end
    tlp_ready = 1'b1;
    tick();
    n_cmp++; if (tlp_hdr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_hdr_drop: got %b want 0", tlp_hdr_valid); end
    tlp_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    logic                 dir [4];
    logic [TAG_WIDTH-1:0] tg  [4];
    logic [REC_WIDTH-1:0] rd  [4];
    int n;
    apply_reset();
    aw_empty = 1'b0; aw_posted = 1'b0; aw_id = 4'd5; aw_len = '0;
    ar_empty = 1'b0; ar_id = 4'd9; w_empty = 1'b0; tlp_ready = 1'b1;
    settle();
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (aw_pop || ar_pop) begin
        dir[n] = aw_pop; tg[n] = rec_addr; rd[n] = rec_data; n++;
      end
      if (n < 4) tick();
    end
    tick();
    aw_empty = 1'b1; ar_empty = 1'b1;
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL rr_grants: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (dir[k] !== ((k % 2) == 0)) begin n_bad++; $display("FAIL rr_dir[%0d]: got %b want %b", k, dir[k], ((k % 2) == 0)); end
      n_cmp++; if (tg[k] !== TAG_WIDTH'(k)) begin n_bad++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, tg[k], k); end
      n_cmp++; if (rd[k] !== (((k % 2) == 0) ? 5'h15 : 5'h09)) begin n_bad++; $display("FAIL rr_rec[%0d]: got %h want %h", k, rd[k], (((k % 2) == 0) ? 5'h15 : 5'h09)); end
    end
    n_cmp++; if (free_tag_count !== 9'd252) begin n_bad++; $display("FAIL rr_count: got %0d want 252", free_tag_count); end
    tick();
    tlp_ready = 1'b0;
  endtask

  task automatic test_wdata_stall;
    int pops;
    logic exp_pop;
    apply_reset();
    aw_empty = 1'b0; aw_posted = 1'b0; aw_id = 4'd2; aw_len = 8'd3;
    w_empty = 1'b0; tlp_ready = 1'b1;
    settle();
    n_cmp++; if ({aw_pop, rec_wr_en, rec_data} !== {2'b11, 5'h12}) begin n_bad++; $display("FAIL wr_grant: got %b want 1110010", {aw_pop, rec_wr_en, rec_data}); end
    tick();
    aw_empty = 1'b1;
    tick();
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      w_empty = (k == 2 || k == 3);
      settle();
      exp_pop = (k < 2 || k == 4 || k == 5);
      if (w_pop === 1'b1) pops++;
      n_cmp++; if ({w_pop, tlp_data_valid} !== {exp_pop, exp_pop}) begin n_bad++; $display("FAIL wr_beat[%0d]: got pop/valid %b want %b", k, {w_pop, tlp_data_valid}, {exp_pop, exp_pop}); end
      tick();
    end
    n_cmp++; if (pops !== 4) begin n_bad++; $display("FAIL wr_pop_total: got %0d want 4", pops); end
    idle_inputs();
  endtask

  task automatic test_tag_exhaust;
    int pops;
    int bad_alloc;
    apply_reset();
    ar_empty = 1'b0; ar_id = 4'd1; tlp_ready = 1'b1; w_empty = 1'b0;
    settle();
    pops = 0; bad_alloc = 0;
    for (int c = 0; c < 1200; c++) begin
      if (ar_pop === 1'b1) begin
        if (rec_addr !== TAG_WIDTH'(pops)) bad_alloc++;
        pops++;
      end
      if (pops == 256) break;
      tick();
    end
    tick();
    tick();
    n_cmp++; if (pops !== 256) begin n_bad++; $display("FAIL ex_pops: got %0d want 256", pops); end
    n_cmp++; if (bad_alloc !== 0) begin n_bad++; $display("FAIL ex_alloc_order: got %0d wrong want 0", bad_alloc); end
    n_cmp++; if ({free_tag_count, ar_pop} !== {9'd0, 1'b0}) begin n_bad++; $display("FAIL ex_empty_pool: got count %0d ar_pop %b want 0 0", free_tag_count, ar_pop); end
    aw_empty = 1'b0; aw_posted = 1'b1; aw_id = 4'd7; aw_len = '0;
    settle();
    n_cmp++; if ({aw_pop, ar_pop, rec_wr_en} !== 3'b100) begin n_bad++; $display("FAIL ex_posted_grant: got %b want 100", {aw_pop, ar_pop, rec_wr_en}); end
    tick();
    aw_empty = 1'b1;
    settle();
    n_cmp++; if ({tlp_hdr_valid, tlp_is_write, tlp_tag, tlp_id} !== {2'b11, 8'd0, 4'd7}) begin n_bad++; $display("FAIL ex_posted_hdr: got %h want 3007", {tlp_hdr_valid, tlp_is_write, tlp_tag, tlp_id}); end
    tick();
    tick();
    n_cmp++; if ({ar_pop, free_tag_count} !== {1'b0, 9'd0}) begin n_bad++; $display("FAIL ex_ar_blocked: got %h want 0", {ar_pop, free_tag_count}); end
    tag_release = 1'b1; tag_release_tag = 8'd17;
    tick();
    tag_release = 1'b0;
    settle();
    n_cmp++; if ({ar_pop, rec_addr, free_tag_count} !== {1'b1, 8'd17, 9'd1}) begin n_bad++; $display("FAIL ex_reuse17: got pop %b addr %0d count %0d want 1 17 1", ar_pop, rec_addr, free_tag_count); end
    tick();
    ar_empty = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_tag_err;
    apply_reset();
    tag_release = 1'b1; tag_release_tag = 8'd5;
    tick();
    tag_release = 1'b0;
    settle();
    n_cmp++; if ({tag_err, free_tag_count} !== {1'b1, 9'd256}) begin n_bad++; $display("FAIL err_double_rel: got err %b count %0d want 1 256", tag_err, free_tag_count); end
    ar_empty = 1'b0; ar_id = 4'd1; tlp_ready = 1'b1;
    settle();
    n_cmp++; if ({ar_pop, rec_addr} !== {1'b1, 8'd0}) begin n_bad++; $display("FAIL err_first_alloc: got pop %b addr %0d want 1 0", ar_pop, rec_addr); end
    tick();
    tick();
    tag_release = 1'b1; tag_release_tag = 8'd0;
    settle();
    n_cmp++; if ({ar_pop, rec_addr} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL err_second_alloc: got pop %b addr %0d want 1 1", ar_pop, rec_addr); end
    tick();
    tag_release = 1'b0; ar_empty = 1'b1;
    settle();
    n_cmp++; if ({tag_err, free_tag_count} !== {1'b1, 9'd255}) begin n_bad++; $display("FAIL err_same_cycle: got err %b count %0d want 1 255", tag_err, free_tag_count); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst;
    apply_reset();
    aw_empty = 1'b0; aw_posted = 1'b0; aw_id = 4'd4; aw_len = 8'd7;
    w_empty = 1'b0; tlp_ready = 1'b1;
    settle();
    n_cmp++; if (aw_pop !== 1'b1) begin n_bad++; $display("FAIL rst_wr_grant: got %b want 1", aw_pop); end
    tick();
    aw_empty = 1'b1;
    tick();
    n_cmp++; if (w_pop !== 1'b1) begin n_bad++; $display("FAIL rst_beat1: got %b want 1", w_pop); end
    tick();
    ARESETn = 1'b0; ar_empty = 1'b0;
    settle();
    n_cmp++; if ({w_pop, ar_pop, aw_pop} !== 3'b000) begin n_bad++; $display("FAIL rst_beat2_gated: got %b want 000", {w_pop, ar_pop, aw_pop}); end
    tick();
    n_cmp++; if ({w_pop, ar_pop, tlp_hdr_valid, tlp_data_valid, rec_wr_en, tag_err, tlp_tag} !== 14'h0) begin n_bad++; $display("FAIL rst_outputs: got %h want 0", {w_pop, ar_pop, tlp_hdr_valid, tlp_data_valid, rec_wr_en, tag_err, tlp_tag}); end
    n_cmp++; if (free_tag_count !== 9'd256) begin n_bad++; $display("FAIL rst_count: got %0d want 256", free_tag_count); end
    ARESETn = 1'b1; ar_empty = 1'b1;
    settle();
    n_cmp++; if ({w_pop, tlp_data_valid, tlp_hdr_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_no_resume: got %b want 000", {w_pop, tlp_data_valid, tlp_hdr_valid}); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_round_robin();
    test_wdata_stall();
    test_tag_exhaust();
    test_tag_err();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
